draw_cmd_dispatch: RTL and testbench

- Front end of the draw pipeline. It accepts draw commands over a valid/ready interface and buffers them in a small FIFO.
- It launches exactly one drawing engine at a time (circle fill/draw, rect fill/draw, line draw, frame update) and broadcasts the command arguments to it.
- It drives the 4-bit SEL code that steers the registered X/Y/colour coordinate muxes back to the framebuffer writer.
- It holds SEL until the active engine reports done, plus one drain cycle for the registered muxes.

---
 rtl/draw_cmd_dispatch.sv | 159 +++++++++++++++
 tb/tb_draw_cmd_dispatch.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_cmd_dispatch.sv
// Draw-pipeline front end: buffers draw commands in a small FIFO, launches one
// engine at a time, and steers the framebuffer coordinate muxes via SEL.
module draw_cmd_dispatch #(
  parameter int X_W        = 10,
  parameter int Y_W        = 9,
  parameter int COLOR_W    = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_op,
  input  logic [X_W-1:0]     cmd_x0,
  input  logic [Y_W-1:0]     cmd_y0,
  input  logic [X_W-1:0]     cmd_x1,
  input  logic [Y_W-1:0]     cmd_y1,
  input  logic [COLOR_W-1:0] cmd_color,
  output logic [5:0]         eng_start,
  input  logic [5:0]         eng_done,
  output logic [X_W-1:0]     arg_x0,
  output logic [Y_W-1:0]     arg_y0,
  output logic [X_W-1:0]     arg_x1,
  output logic [Y_W-1:0]     arg_y1,
  output logic [COLOR_W-1:0] arg_color,
  output logic [3:0]         SEL,
  output logic               busy,
  output logic               err_op,
  output logic               err_timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  localparam int EW = 4 + 2 * X_W + 2 * Y_W + COLOR_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [3:0]    SEL_IDLE   = 4'd15;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  logic [EW-1:0]      mem [FIFO_DEPTH];
  logic [AW:0]        wr_ptr, rd_ptr;
  logic               full, empty, push, pop;

  logic [3:0]         head_op;
  logic [X_W-1:0]     head_x0, head_x1;
  logic [Y_W-1:0]     head_y0, head_y1;
  logic [COLOR_W-1:0] head_color;
  logic [5:0]         head_onehot;

  logic [1:0]         state;
  logic [5:0]         cur_onehot;
  logic [TW-1:0]      timer;

  // The extra pointer bit distinguishes a full ring from an empty one.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = (state == S_IDLE) && !empty;
  assign busy      = (state != S_IDLE) || !empty;

  assign {head_op, head_x0, head_y0, head_x1, head_y1, head_color} = mem[rd_ptr[AW-1:0]];

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    head_onehot = '0;
    case (head_op)
      4'd0:    head_onehot = 6'b000001;
      4'd1:    head_onehot = 6'b000010;
      4'd2:    head_onehot = 6'b000100;
      4'd3:    head_onehot = 6'b001000;
      4'd4:    head_onehot = 6'b010000;
      4'd10:   head_onehot = 6'b100000;
      default: head_onehot = '0;
    endcase
  end

  // NOTE: command storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= S_IDLE;
      SEL         <= SEL_IDLE;
      cur_onehot  <= '0;
      eng_start   <= '0;
      timer       <= '0;
      err_op      <= 1'b0;
      err_timeout <= 1'b0;
      arg_x0      <= '0;
      arg_y0      <= '0;
      arg_x1      <= '0;
      arg_y1      <= '0;
      arg_color   <= '0;
    end else begin
      eng_start   <= '0;
      err_op      <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            if (|head_onehot) begin
              arg_x0     <= head_x0;
              arg_y0     <= head_y0;
              arg_x1     <= head_x1;
              arg_y1     <= head_y1;
              arg_color  <= head_color;
              SEL        <= head_op;
              cur_onehot <= head_onehot;
              eng_start  <= head_onehot;
              state      <= S_START;
            end else begin
              err_op <= 1'b1;
            end
          end
        end
        S_START: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // Done from the active engine wins over a same-cycle timeout.
          if (|(eng_done & cur_onehot)) begin
            state <= S_DRAIN;
          end else if (timer == TIMER_LAST) begin
            err_timeout <= 1'b1;
            state       <= S_DRAIN;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DRAIN: begin
          SEL   <= SEL_IDLE;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_cmd_dispatch.sv
// Bench for draw_cmd_dispatch: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a command-queue reference model.
module tb_draw_cmd_dispatch;

  localparam int X_W          = 10;
  localparam int Y_W          = 9;
  localparam int COLOR_W      = 8;
  localparam int FIFO_DEPTH   = 4;
  localparam int MAIN_TIMEOUT = 4096;
  localparam logic [3:0] LEGAL [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd10};

  typedef struct packed {
    logic [3:0]         op;
    logic [X_W-1:0]     x0;
    logic [Y_W-1:0]     y0;
    logic [X_W-1:0]     x1;
    logic [Y_W-1:0]     y1;
    logic [COLOR_W-1:0] color;
  } cmd_t;

  logic               CLK = 1'b0;
  logic               RST_N;
  logic               cmd_valid;
  logic [3:0]         cmd_op;
  logic [X_W-1:0]     cmd_x0, cmd_x1;
  logic [Y_W-1:0]     cmd_y0, cmd_y1;
  logic [COLOR_W-1:0] cmd_color;
  logic [5:0]         eng_done;
  logic               cmd_ready, busy, err_op, err_timeout;
  logic [5:0]         eng_start;
  logic [X_W-1:0]     arg_x0, arg_x1;
  logic [Y_W-1:0]     arg_y0, arg_y1;
  logic [COLOR_W-1:0] arg_color;
  logic [3:0]         SEL;

  // Second instance with a short timeout for the abort scenario.
  logic               t_cmd_valid;
  logic [3:0]         t_cmd_op;
  logic [5:0]         t_eng_done;
  logic               t_cmd_ready, t_busy, t_err_op, t_err_timeout;
  logic [5:0]         t_eng_start;
  logic [X_W-1:0]     t_arg_x0, t_arg_x1;
  logic [Y_W-1:0]     t_arg_y0, t_arg_y1;
  logic [COLOR_W-1:0] t_arg_color;
  logic [3:0]         t_sel;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  always #5 CLK = ~CLK;

  draw_cmd_dispatch #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W),
                      .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(MAIN_TIMEOUT)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1),
    .cmd_y1(cmd_y1), .cmd_color(cmd_color), .eng_start(eng_start),
    .eng_done(eng_done), .arg_x0(arg_x0), .arg_y0(arg_y0), .arg_x1(arg_x1),
    .arg_y1(arg_y1), .arg_color(arg_color), .SEL(SEL), .busy(busy),
    .err_op(err_op), .err_timeout(err_timeout));

  draw_cmd_dispatch #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W),
                      .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(16)) u_to (
    .CLK(CLK), .RST_N(RST_N), .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready),
    .cmd_op(t_cmd_op), .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1),
    .cmd_y1(cmd_y1), .cmd_color(cmd_color), .eng_start(t_eng_start),
    .eng_done(t_eng_done), .arg_x0(t_arg_x0), .arg_y0(t_arg_y0), .arg_x1(t_arg_x1),
    .arg_y1(t_arg_y1), .arg_color(t_arg_color), .SEL(t_sel), .busy(t_busy),
    .err_op(t_err_op), .err_timeout(t_err_timeout));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] op_onehot(input logic [3:0] op);
    for (int i = 0; i < 6; i++) if (op == LEGAL[i]) return 6'(1 << i);
    return 6'd0;
  endfunction

  // Reference model: a queue of pending commands plus the one in service,
  // tracked by how many cycles have elapsed since it left the queue.
  cmd_t m_q[$];
  cmd_t m_cur;
  bit   m_active, m_drain, m_err_op, m_err_to;
  int   m_life;

  always @(posedge CLK or negedge RST_N) begin : model
    cmd_t inc, h;
    bit   do_push;
    if (!RST_N) begin
      m_q.delete();
      m_cur    = '0;
      m_active = 1'b0;
      m_drain  = 1'b0;
      m_err_op = 1'b0;
      m_err_to = 1'b0;
      m_life   = 0;
    end else begin
      do_push  = cmd_valid && (m_q.size() < FIFO_DEPTH);
      inc      = '{cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color};
      m_err_op = 1'b0;
      m_err_to = 1'b0;
      if (m_active) begin
        if (m_drain) m_active = 1'b0;
        else if (m_life == 1) m_life = 2;
        else if ((eng_done & op_onehot(m_cur.op)) != 6'd0) m_drain = 1'b1;
        else if (m_life - 1 == MAIN_TIMEOUT) begin
          m_drain  = 1'b1;
          m_err_to = 1'b1;
        end else m_life++;
      end else if (m_q.size() > 0) begin
        h = m_q.pop_front();
        if (op_onehot(h.op) != 6'd0) begin
          m_active = 1'b1;
          m_drain  = 1'b0;
          m_life   = 1;
          m_cur    = h;
        end else m_err_op = 1'b1;
      end
      if (do_push) m_q.push_back(inc);
    end
  end

  always @(negedge CLK) begin
    if (RST_N && cmp_en) begin
      check("cmp_ready", cmd_ready, m_q.size() < FIFO_DEPTH);
      check("cmp_sel", SEL, m_active ? m_cur.op : 4'd15);
      check("cmp_start", eng_start, (m_active && m_life == 1) ? op_onehot(m_cur.op) : 6'd0);
      check("cmp_busy", busy, m_active || m_q.size() != 0);
      check("cmp_err_op", err_op, m_err_op);
      check("cmp_err_timeout", err_timeout, m_err_to);
      if (m_active)
        check("cmp_args", {arg_x0, arg_y0, arg_x1, arg_y1, arg_color},
              {m_cur.x0, m_cur.y0, m_cur.x1, m_cur.y1, m_cur.color});
    end
  end

  task automatic drive_cmd(input logic [3:0] op, input int x0, input int y0,
                           input int x1, input int y1, input int color);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_x0    = X_W'(x0);
    cmd_y0    = Y_W'(y0);
    cmd_x1    = X_W'(x1);
    cmd_y1    = Y_W'(y1);
    cmd_color = COLOR_W'(color);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_sel"}, SEL, 4'd15);
    check({tag, "_ready"}, cmd_ready, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_start"}, eng_start, 6'd0);
    check({tag, "_args"}, {arg_x0, arg_y0, arg_x1, arg_y1, arg_color}, 64'd0);
    check({tag, "_errs"}, {err_op, err_timeout}, 2'b00);
  endtask

  task automatic drain_all(input string tag);
    int n = 0;
    cmd_valid = 1'b0;
    eng_done  = 6'h3F;
    while (busy && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check(tag, busy, 1'b0);
    eng_done = 6'd0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    RST_N       = 1'b1;
    cmd_valid   = 1'b0;
    eng_done    = 6'd0;
    t_cmd_valid = 1'b0;
    t_cmd_op    = 4'd0;
    t_eng_done  = 6'd0;
    drive_cmd(4'd0, 0, 0, 0, 0, 0);
    cmd_valid = 1'b0;

    // Asynchronous reset before any clock edge.
    #3 RST_N = 1'b0;
    #1 check_reset("rst_async");
    check("rst_t_sel", t_sel, 4'd15);
    repeat (3) @(negedge CLK);
    RST_N  = 1'b1;
    cmp_en = 1'b1;

    // RF dispatch with done 7 cycles after the start cycle.
    @(negedge CLK); drive_cmd(4'd2, 10, 20, 100, 50, 8'h3C);
    @(negedge CLK); cmd_valid = 1'b0;
    check("rf_busy_queued", busy, 1'b1);
    check("rf_sel_before", SEL, 4'd15);
    @(negedge CLK);
    check("rf_start", eng_start, 6'b000100);
    check("rf_sel_start", SEL, 4'd2);
    check("rf_model_sel", m_cur.op, 4'd2);
    check("rf_args_start", {arg_x0, arg_y0, arg_x1, arg_y1, arg_color},
          {10'd10, 9'd20, 10'd100, 9'd50, 8'h3C});
    for (int i = 0; i < 7; i++) begin
      @(negedge CLK);
      check("rf_start_once", eng_start, 6'd0);
      check("rf_sel_wait", SEL, 4'd2);
      if (i == 6) eng_done = 6'b000100;
    end
    @(negedge CLK); eng_done = 6'd0;
    check("rf_sel_drain", SEL, 4'd2);
    check("rf_args_drain", {arg_x0, arg_y0, arg_x1, arg_y1, arg_color},
          {10'd10, 9'd20, 10'd100, 9'd50, 8'h3C});
    check("rf_busy_drain", busy, 1'b1);
    @(negedge CLK);
    check("rf_sel_idle", SEL, 4'd15);
    check("rf_busy_idle", busy, 1'b0);

    // Backpressure: six back-to-back LD pushes with no done.
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      check("bp_ready", cmd_ready, i < 5);
      drive_cmd(4'd4, i, i + 1, i + 2, i + 3, i + 4);
    end
    @(negedge CLK);
    check("bp_ready_full", cmd_ready, 1'b0);
    check("bp_sel_first", SEL, 4'd4);
    eng_done = 6'b010000;
    @(negedge CLK); eng_done = 6'd0;
    check("bp_ready_drain", cmd_ready, 1'b0);
    @(negedge CLK);
    check("bp_ready_idle", cmd_ready, 1'b0);
    check("bp_sel_idle", SEL, 4'd15);
    @(negedge CLK);
    check("bp_ready_freed", cmd_ready, 1'b1);
    check("bp_next_start", eng_start, 6'b010000);
    @(negedge CLK); cmd_valid = 1'b0;
    check("bp_ready_refull", cmd_ready, 1'b0);
    drain_all("bp_drain");

    // Illegal opcode 7 followed by frame update.
    @(negedge CLK); drive_cmd(4'd7, 1, 2, 3, 4, 5);
    @(negedge CLK); drive_cmd(4'd10, 6, 7, 8, 9, 10);
    @(negedge CLK); cmd_valid = 1'b0;
    check("ill_err_op", err_op, 1'b1);
    check("ill_sel", SEL, 4'd15);
    check("ill_no_start", eng_start, 6'd0);
    @(negedge CLK);
    check("ill_err_op_once", err_op, 1'b0);
    check("fu_sel", SEL, 4'd10);
    check("fu_start", eng_start, 6'b100000);
    drain_all("ill_drain");

    // Timeout on the short-timeout instance, with a wrong-engine done held.
    @(negedge CLK);
    t_cmd_valid = 1'b1;
    t_cmd_op    = 4'd1;
    cmd_x0 = 10'd5; cmd_y0 = 9'd6; cmd_x1 = 10'd7; cmd_y1 = 9'd8; cmd_color = 8'd9;
    @(negedge CLK);
    t_cmd_valid = 1'b0;
    t_eng_done  = 6'b000001;
    @(negedge CLK);
    check("to_start", t_eng_start, 6'b000010);
    check("to_sel_start", t_sel, 4'd1);
    check("to_ready", t_cmd_ready, 1'b1);
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      check("to_no_err_early", t_err_timeout, 1'b0);
      check("to_sel_wait", t_sel, 4'd1);
      check("to_no_restart", t_eng_start, 6'd0);
    end
    @(negedge CLK);
    check("to_err_timeout", t_err_timeout, 1'b1);
    check("to_sel_drain", t_sel, 4'd1);
    check("to_args_drain", {t_arg_x0, t_arg_y0, t_arg_x1, t_arg_y1, t_arg_color},
          {10'd5, 9'd6, 10'd7, 9'd8, 8'd9});
    check("to_no_err_op", t_err_op, 1'b0);
    @(negedge CLK);
    t_eng_done = 6'd0;
    check("to_err_once", t_err_timeout, 1'b0);
    check("to_sel_idle", t_sel, 4'd15);
    check("to_busy_idle", t_busy, 1'b0);

    // Reset while waiting with two commands queued.
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      drive_cmd(4'd0, 3 * i, i, 2 * i, 1, 7);
    end
    @(negedge CLK); cmd_valid = 1'b0;
    repeat (3) @(negedge CLK);
    check("mr_sel_wait", SEL, 4'd0);
    check("mr_busy", busy, 1'b1);
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1 check_reset("mr_async");
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check("mr_no_start", eng_start, 6'd0);
      check("mr_idle", {busy, SEL}, {1'b0, 4'd15});
    end

    // Randomized traffic: heavy load first, then sparse.
    for (int c = 0; c < 2400; c++) begin
      @(negedge CLK);
      cmd_valid = (c < 1200) ? ($urandom_range(2, 0) != 0) : ($urandom_range(5, 0) == 0);
      r = $urandom_range(7, 0);
      if (r < 6)       cmd_op = LEGAL[r];
      else if (r == 6) cmd_op = 4'($urandom_range(9, 5));
      else             cmd_op = 4'($urandom);
      cmd_x0    = X_W'($urandom);
      cmd_y0    = Y_W'($urandom);
      cmd_x1    = X_W'($urandom);
      cmd_y1    = Y_W'($urandom);
      cmd_color = COLOR_W'($urandom);
      eng_done  = 6'($urandom & $urandom);
    end
    drain_all("rand_drain");
    repeat (2) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
